// File: rtl/vram_arbiter_if.sv
// Display/writer/VRAM signal bundle for the VRAM arbiter.
// The slave side is the arbiter; the master side is the display, writer and memory.
interface vram_arbiter_if;
  logic        PIX_TICK;
  logic        BLANK;
  logic [18:0] PIXEL;
  logic        WR_REQ;
  logic [18:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        WR_ACK;
  logic        WR_ERR;
  logic [18:0] MEM_ADDR;
  logic        MEM_WE;
  logic [7:0]  MEM_DIN;
  logic [7:0]  MEM_DOUT;
  logic [7:0]  RGB_OUT;
  logic        OVERRUN;

  modport slave (
    input  PIX_TICK, BLANK, PIXEL, WR_REQ, WR_ADDR, WR_DATA, MEM_DOUT,
    output WR_ACK, WR_ERR, MEM_ADDR, MEM_WE, MEM_DIN, RGB_OUT, OVERRUN
  );

  modport master (
    output PIX_TICK, BLANK, PIXEL, WR_REQ, WR_ADDR, WR_DATA, MEM_DOUT,
    input  WR_ACK, WR_ERR, MEM_ADDR, MEM_WE, MEM_DIN, RGB_OUT, OVERRUN
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between display reads (RGB_OUT 3 cycles after a tick, 4-5 if deferred)
// and held writes; a write waits while a display read is active or pending, a lost read sets OVERRUN.
module vram_arbiter #(
  parameter int unsigned ADDR_MAX = 307200
) (
  input logic           CLK,
  input logic           RESET,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, CAP = 2'd2, WR = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic [18:0] rd_addr_q, rd_addr_d;
  logic [1:0]  blank_dly_q, blank_dly_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_din_q, mem_din_d;
  logic        wr_ack_q, wr_ack_d;
  logic        wr_err_q, wr_err_d;
  logic [7:0]  rgb_out_q, rgb_out_d;
  logic        overrun_q, overrun_d;

  logic disp_tick, blank_tick, wr_bad;
  logic go_rd, go_wr;

  assign disp_tick  = bus.PIX_TICK & ~bus.BLANK;
  assign blank_tick = bus.PIX_TICK & bus.BLANK;
  assign wr_bad     = 32'(bus.WR_ADDR) >= ADDR_MAX;

  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    blank_dly_d = {blank_dly_q[0], blank_tick};
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_din_d   = mem_din_q;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;
    rgb_out_d   = rgb_out_q;
    overrun_d   = overrun_q;
    go_rd       = 1'b0;
    go_wr       = 1'b0;

    // Every display tick is latched; a second one before service loses the first.
    if (disp_tick) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.PIXEL;
      if (rd_pend_q) overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (disp_tick || rd_pend_q) go_rd = 1'b1;
        else if (bus.WR_REQ)        go_wr = 1'b1;
      end
      RD:  state_d = CAP;
      // CAP may hand straight to a write, but only when no read is waiting.
      CAP: begin
        state_d = IDLE;
        if (!disp_tick && !rd_pend_q && bus.WR_REQ) go_wr = 1'b1;
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_rd) begin
      state_d    = RD;
      rd_pend_d  = 1'b0;
      mem_addr_d = disp_tick ? bus.PIXEL : rd_addr_q;
    end

    if (go_wr) begin
      state_d    = WR;
      mem_addr_d = bus.WR_ADDR;
      mem_din_d  = bus.WR_DATA;
      mem_we_d   = ~wr_bad;
      wr_ack_d   = 1'b1;
      wr_err_d   = wr_bad;
    end

    // The blank marker's third stage is the RGB register itself, matching RD/CAP/RGB.
    if (state_q == CAP)      rgb_out_d = bus.MEM_DOUT;
    else if (blank_dly_q[1]) rgb_out_d = 8'h00;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      blank_dly_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_din_q   <= '0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      rgb_out_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      blank_dly_q <= blank_dly_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_din_q   <= mem_din_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      rgb_out_q   <= rgb_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.MEM_ADDR = mem_addr_q;
  assign bus.MEM_WE   = mem_we_q;
  assign bus.MEM_DIN  = mem_din_q;
  assign bus.WR_ACK   = wr_ack_q;
  assign bus.WR_ERR   = wr_err_q;
  assign bus.RGB_OUT  = rgb_out_q;
  assign bus.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, port-reservation reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_vram_arbiter;
  localparam int unsigned AMAX = 307200;

  logic CLK;
  logic RESET;
  vram_arbiter_if bus ();

  vram_arbiter #(.ADDR_MAX(AMAX)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // VRAM: synchronous, read-before-write, data one cycle after the address.
  logic [7:0] ram   [int];
  logic [7:0] m_ram [int];

  always @(posedge CLK) begin
    bus.MEM_DOUT <= ram.exists(int'(bus.MEM_ADDR)) ? ram[int'(bus.MEM_ADDR)] : 8'h00;
    if (bus.MEM_WE) ram[int'(bus.MEM_ADDR)] = bus.MEM_DIN;
  end

  // Reference model: the port is a reserved resource. A read takes two slots and
  // frees the port for reads three cycles later and for writes two cycles later;
  // a write takes one slot. Outputs are scheduled as events in future cycles.
  int          cur = 0;
  int          rd_free = 0;
  int          wr_free = 0;
  logic        pend = 1'b0;
  logic [18:0] paddr = '0;
  logic        m_ovr = 1'b0;

  logic        ev_mem  [8];
  logic        ev_isw  [8];
  logic [18:0] ev_addr [8];
  logic [7:0]  ev_din  [8];
  logic        ev_we   [8];
  logic        ev_err  [8];
  logic        ev_rgb  [8];
  logic [7:0]  ev_rgbv [8];

  logic [18:0] e_addr = '0;
  logic [7:0]  e_din  = '0;
  logic        e_we   = 1'b0;
  logic        e_ack  = 1'b0;
  logic        e_err  = 1'b0;
  logic [7:0]  e_rgb  = '0;
  logic        e_ovr  = 1'b0;

  always @(posedge CLK) begin : model
    int s1, s3, sn;
    logic bad;
    if (!RESET) begin
      cur = 0; rd_free = 0; wr_free = 0; pend = 1'b0; paddr = '0; m_ovr = 1'b0;
      for (int i = 0; i < 8; i++) begin
        ev_mem[i] = 1'b0; ev_rgb[i] = 1'b0;
      end
      e_addr = '0; e_din = '0; e_we = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_rgb = '0; e_ovr = 1'b0;
    end else begin
      s1 = (cur + 1) % 8;
      s3 = (cur + 3) % 8;
      if (bus.PIX_TICK && !bus.BLANK) begin
        if (pend) m_ovr = 1'b1;
        pend  = 1'b1;
        paddr = bus.PIXEL;
      end
      if (bus.PIX_TICK && bus.BLANK) begin
        ev_rgb[s3] = 1'b1; ev_rgbv[s3] = 8'h00;
      end
      if (pend && cur >= rd_free) begin
        ev_mem[s1] = 1'b1; ev_isw[s1] = 1'b0; ev_addr[s1] = paddr;
        ev_rgb[s3] = 1'b1;
        ev_rgbv[s3] = m_ram.exists(int'(paddr)) ? m_ram[int'(paddr)] : 8'h00;
        pend = 1'b0; rd_free = cur + 3; wr_free = cur + 2;
      end else if (!pend && bus.WR_REQ && cur >= wr_free) begin
        bad = (32'(bus.WR_ADDR) >= AMAX);
        ev_mem[s1] = 1'b1; ev_isw[s1] = 1'b1; ev_addr[s1] = bus.WR_ADDR;
        ev_din[s1] = bus.WR_DATA; ev_we[s1] = !bad; ev_err[s1] = bad;
        if (!bad) m_ram[int'(bus.WR_ADDR)] = bus.WR_DATA;
        rd_free = cur + 2; wr_free = cur + 2;
      end
      cur++;
      sn = cur % 8;
      e_we = 1'b0; e_ack = 1'b0; e_err = 1'b0;
      if (ev_mem[sn]) begin
        e_addr = ev_addr[sn];
        if (ev_isw[sn]) begin
          e_din = ev_din[sn]; e_we = ev_we[sn]; e_ack = 1'b1; e_err = ev_err[sn];
        end
        ev_mem[sn] = 1'b0;
      end
      if (ev_rgb[sn]) begin
        e_rgb = ev_rgbv[sn];
        ev_rgb[sn] = 1'b0;
      end
      e_ovr = m_ovr;
    end
    #1;
    chk("model_mem_addr", 32'(bus.MEM_ADDR), 32'(e_addr));
    chk("model_mem_din",  32'(bus.MEM_DIN),  32'(e_din));
    chk("model_mem_we",   32'(bus.MEM_WE),   32'(e_we));
    chk("model_wr_ack",   32'(bus.WR_ACK),   32'(e_ack));
    chk("model_wr_err",   32'(bus.WR_ERR),   32'(e_err));
    chk("model_rgb_out",  32'(bus.RGB_OUT),  32'(e_rgb));
    chk("model_overrun",  32'(bus.OVERRUN),  32'(e_ovr));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin : stim
    int acks;
    RESET = 1'b0;
    bus.PIX_TICK = 1'b0; bus.BLANK = 1'b0; bus.PIXEL = '0;
    bus.WR_REQ = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
    ram[641] = 8'hE0; m_ram[641] = 8'hE0;
    ram[900] = 8'h9A; m_ram[900] = 8'h9A;

    idle(3);
    chk("rst_rgb", 32'(bus.RGB_OUT), 32'h0);
    chk("rst_we", 32'(bus.MEM_WE), 32'h0);
    chk("rst_addr", 32'(bus.MEM_ADDR), 32'h0);
    chk("rst_ovr", 32'(bus.OVERRUN), 32'h0);
    @(negedge CLK) RESET = 1'b1;
    idle(2);

    // Display read of pixel 641, first tick after reset.
    @(negedge CLK); bus.PIX_TICK = 1'b1; bus.BLANK = 1'b0; bus.PIXEL = 19'd641;
    step();
    chk("rd_addr_t1", 32'(bus.MEM_ADDR), 32'd641);
    chk("rd_we_t1", 32'(bus.MEM_WE), 32'h0);
    @(negedge CLK) bus.PIX_TICK = 1'b0;
    step(); step();
    chk("rd_rgb_t3", 32'(bus.RGB_OUT), 32'hE0);
    idle(2);

    // Plain write.
    @(negedge CLK); bus.WR_REQ = 1'b1; bus.WR_ADDR = 19'd100; bus.WR_DATA = 8'h1C;
    step();
    chk("wr_we", 32'(bus.MEM_WE), 32'h1);
    chk("wr_ack", 32'(bus.WR_ACK), 32'h1);
    chk("wr_addr", 32'(bus.MEM_ADDR), 32'd100);
    chk("wr_din", 32'(bus.MEM_DIN), 32'h1C);
    @(negedge CLK) bus.WR_REQ = 1'b0;
    step();
    chk("wr_ack_pulse", 32'(bus.WR_ACK), 32'h0);
    chk("ram100", 32'(ram[100]), 32'h1C);
    idle(2);

    // Tick and write in the same cycle: RD, CAP, WR.
    @(negedge CLK);
    bus.PIX_TICK = 1'b1; bus.PIXEL = 19'd641;
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 19'd200; bus.WR_DATA = 8'h55;
    step();
    chk("coll_rd_addr", 32'(bus.MEM_ADDR), 32'd641);
    chk("coll_ack_t1", 32'(bus.WR_ACK), 32'h0);
    @(negedge CLK) bus.PIX_TICK = 1'b0;
    step();
    chk("coll_ack_t2", 32'(bus.WR_ACK), 32'h0);
    step();
    chk("coll_ack_t3", 32'(bus.WR_ACK), 32'h1);
    chk("coll_we_t3", 32'(bus.MEM_WE), 32'h1);
    chk("coll_addr_t3", 32'(bus.MEM_ADDR), 32'd200);
    chk("coll_rgb_t3", 32'(bus.RGB_OUT), 32'hE0);
    @(negedge CLK) bus.WR_REQ = 1'b0;
    idle(3);

    // Tick arriving during WR is deferred to the next IDLE.
    @(negedge CLK); bus.WR_REQ = 1'b1; bus.WR_ADDR = 19'd300; bus.WR_DATA = 8'h33;
    step();
    chk("def_wr_ack", 32'(bus.WR_ACK), 32'h1);
    @(negedge CLK); bus.WR_REQ = 1'b0; bus.PIX_TICK = 1'b1; bus.PIXEL = 19'd100;
    step();
    chk("def_idle_we", 32'(bus.MEM_WE), 32'h0);
    @(negedge CLK) bus.PIX_TICK = 1'b0;
    step();
    chk("def_rd_addr", 32'(bus.MEM_ADDR), 32'd100);
    step(); step();
    chk("def_rgb", 32'(bus.RGB_OUT), 32'h1C);
    chk("def_ovr", 32'(bus.OVERRUN), 32'h0);
    idle(2);

    // Out-of-range write is acknowledged with an error and discarded; last valid address writes.
    @(negedge CLK); bus.WR_REQ = 1'b1; bus.WR_ADDR = 19'd307200; bus.WR_DATA = 8'hFF;
    step();
    chk("err_ack", 32'(bus.WR_ACK), 32'h1);
    chk("err_err", 32'(bus.WR_ERR), 32'h1);
    chk("err_we", 32'(bus.MEM_WE), 32'h0);
    @(negedge CLK) bus.WR_REQ = 1'b0;
    step();
    @(negedge CLK); bus.WR_REQ = 1'b1; bus.WR_ADDR = 19'd307199; bus.WR_DATA = 8'h07;
    step();
    chk("edge_err", 32'(bus.WR_ERR), 32'h0);
    chk("edge_we", 32'(bus.MEM_WE), 32'h1);
    @(negedge CLK) bus.WR_REQ = 1'b0;
    idle(3);

    // Write burst with a blanking tick in the middle.
    acks = 0;
    @(negedge CLK); bus.WR_REQ = 1'b1; bus.WR_ADDR = 19'd400; bus.WR_DATA = 8'h40;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge CLK);
      bus.PIX_TICK = (i == 1);
      bus.BLANK    = (i == 1);
      step();
      if (bus.WR_ACK) begin
        acks++;
        bus.WR_ADDR = 19'(400 + acks);
        bus.WR_DATA = 8'(8'h40 + acks);
      end
      if (i == 2) chk("blank_rgb_t2", 32'(bus.RGB_OUT), 32'h1C);
      if (i == 3) chk("blank_rgb_t3", 32'(bus.RGB_OUT), 32'h00);
    end
    @(negedge CLK); bus.WR_REQ = 1'b0; bus.BLANK = 1'b0;
    step();
    chk("burst_acks", 32'(acks), 32'd4);
    chk("ram403", 32'(ram[403]), 32'h43);
    idle(2);

    // Reset in the middle of a write cycle.
    @(negedge CLK); bus.WR_REQ = 1'b1; bus.WR_ADDR = 19'd500; bus.WR_DATA = 8'hAA;
    step();
    chk("rstwr_we_before", 32'(bus.MEM_WE), 32'h1);
    #2;
    RESET = 1'b0; bus.WR_REQ = 1'b0;
    #1;
    chk("rstwr_we_now", 32'(bus.MEM_WE), 32'h0);
    chk("rstwr_ack_now", 32'(bus.WR_ACK), 32'h0);
    @(negedge CLK);
    step();
    @(negedge CLK) RESET = 1'b1;
    step();
    chk("rstwr_no_ack", 32'(bus.WR_ACK), 32'h0);
    chk("ram500_kept", 32'(ram.exists(500)), 32'h0);

    @(negedge CLK); bus.PIX_TICK = 1'b1; bus.PIXEL = 19'd641;
    step();
    @(negedge CLK) bus.PIX_TICK = 1'b0;
    step(); step();
    chk("post_rst_rgb", 32'(bus.RGB_OUT), 32'hE0);
    idle(2);

    // Ticks too close together: the second is pending, the third overruns it.
    @(negedge CLK); bus.PIX_TICK = 1'b1; bus.PIXEL = 19'd641;
    step();
    @(negedge CLK) bus.PIXEL = 19'd800;
    step();
    @(negedge CLK) bus.PIXEL = 19'd900;
    step();
    chk("ovr_set", 32'(bus.OVERRUN), 32'h1);
    chk("ovr_first_rgb", 32'(bus.RGB_OUT), 32'hE0);
    @(negedge CLK) bus.PIX_TICK = 1'b0;
    step();
    chk("ovr_repl_addr", 32'(bus.MEM_ADDR), 32'd900);
    step(); step();
    chk("ovr_repl_rgb", 32'(bus.RGB_OUT), 32'h9A);
    idle(3);
    chk("ovr_sticky", 32'(bus.OVERRUN), 32'h1);
    @(negedge CLK) RESET = 1'b0;
    step();
    chk("ovr_cleared", 32'(bus.OVERRUN), 32'h0);
    @(negedge CLK) RESET = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have a parameter ADDR_MAX, default 307200, giving the number of valid pixel addresses (640x480).
REQ-002 The block SHALL have an input CLK, 1 bit: the system clock, running at 4x the pixel rate.
REQ-003 The block SHALL have an input RESET, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have an input PIX_TICK, 1 bit: a one-cycle pulse per pixel, at most once every 4 CLK cycles.
REQ-005 The block SHALL have an input BLANK, 1 bit: 1 = blanking interval, sampled with PIX_TICK.
REQ-006 The block SHALL have an input PIXEL, 19 bits: the display pixel address (h + 640v), sampled with PIX_TICK.
REQ-007 The block SHALL have an input WR_REQ, 1 bit: a write request, held with WR_ADDR and WR_DATA until WR_ACK.
REQ-008 The block SHALL have an input WR_ADDR, 19 bits: the write address.
REQ-009 The block SHALL have an input WR_DATA, 8 bits: the write pixel data (RGB 3-3-2).
REQ-010 The block SHALL have an output WR_ACK, 1 bit: a one-cycle pulse when the request is consumed.
REQ-011 The block SHALL have an output WR_ERR, 1 bit: a one-cycle pulse with WR_ACK when WR_ADDR >= ADDR_MAX.
REQ-012 The block SHALL have an output MEM_ADDR, 19 bits, registered: the single-port VRAM address.
REQ-013 The block SHALL have an output MEM_WE, 1 bit, registered: the VRAM write enable.
REQ-014 The block SHALL have an output MEM_DIN, 8 bits, registered: the VRAM write data.
REQ-015 The block SHALL have an input MEM_DOUT, 8 bits: VRAM read data, valid one cycle after MEM_ADDR is presented.
REQ-016 The block SHALL have an output RGB_OUT, 8 bits, registered: the pixel colour to the DAC.
REQ-017 The block SHALL have an output OVERRUN, 1 bit, sticky: a display read was lost.

Function
REQ-018 The FSM SHALL have the states IDLE, RD, CAP and WR; every non-IDLE state SHALL last exactly 1 cycle.
- RD: MEM_ADDR = read address, MEM_WE = 0.
- CAP: RGB_OUT is loaded from MEM_DOUT.
REQ-019 A display tick (PIX_TICK=1, BLANK=0) sampled in IDLE SHALL cause the transition IDLE->RD->CAP->IDLE; RGB_OUT SHALL update at cycle t+3 for a tick at cycle t.
REQ-020 A display tick sampled in RD, CAP or WR SHALL set rd_pend and latch PIXEL.
- The pending read SHALL be issued from the next IDLE, with priority over WR_REQ.
- RGB_OUT latency for a pending read is therefore 4 to 5 cycles.
REQ-021 A display tick arriving while rd_pend=1 SHALL set OVERRUN and replace the latched address.
REQ-022 A blanking tick (PIX_TICK=1, BLANK=1) SHALL NOT access memory.
- RGB_OUT SHALL become 0 exactly 3 cycles later, via a 3-stage delay of the blank marker.
- The memory port SHALL remain available for writes.
REQ-023 In IDLE with WR_REQ=1 and no display tick and no rd_pend, the next state SHALL be WR.
- In WR: MEM_ADDR = WR_ADDR, MEM_DIN = WR_DATA, MEM_WE = 1, WR_ACK = 1.
REQ-024 If WR_ADDR >= ADDR_MAX, WR SHALL assert WR_ACK and WR_ERR with MEM_WE=0 (write discarded).
REQ-025 A display tick and WR_REQ in the same IDLE cycle SHALL resolve as read first; the write SHALL be issued after CAP.
REQ-026 WR_REQ SHALL be ignored in the WR cycle itself; the earliest back-to-back write is WR, IDLE, WR.
REQ-027 MEM_WE SHALL be 1 only in WR; MEM_ADDR and MEM_DIN SHALL hold their last value in IDLE.
REQ-028 OVERRUN SHALL be cleared only by reset.

Reset
REQ-029 RESET=0 SHALL asynchronously force state IDLE, rd_pend 0, the delay line 0, MEM_WE 0, WR_ACK 0, WR_ERR 0, MEM_ADDR 0, MEM_DIN 0, RGB_OUT 0 and OVERRUN 0.
REQ-030 Reset asserted mid-WR SHALL drop MEM_WE immediately and abort the write; no WR_ACK SHALL follow.
REQ-031 After RESET rises, the first PIX_TICK SHALL be serviced normally.

Verification
REQ-032 The bench SHALL cover: PIX_TICK, BLANK=0, PIXEL=641, RAM[641]=8'hE0 -> MEM_ADDR=641 at t+1, RGB_OUT=8'hE0 at t+3.
REQ-033 The bench SHALL cover: WR_REQ, WR_ADDR=100, WR_DATA=8'h1C, no tick -> WR at t+1 with MEM_WE=1, WR_ACK=1; RAM[100]=8'h1C.
REQ-034 The bench SHALL cover: a tick and WR_REQ in the same cycle -> RD, CAP, WR order; WR_ACK at t+3.
REQ-035 The bench SHALL cover: a tick one cycle into WR -> pending read issued at the first IDLE, OVERRUN stays 0.
REQ-036 The bench SHALL cover: WR_ADDR=307200 -> WR_ACK=1, WR_ERR=1, MEM_WE=0.
REQ-037 The bench SHALL cover: a BLANK=1 tick during a write burst -> writes proceed, RGB_OUT=0 at t+3; RESET low mid-WR -> MEM_WE=0 within the same cycle.
